// File: rtl/round_ctrl.sv
// Whack-a-mole round sequencer: round number, countdown, intermission, score.
// Optional pause input enabled by defining ROUND_PAUSE_EN.
module round_ctrl #(
    parameter int CLK_HZ     = 25000000,
    parameter int ROUND_SECS = 30,
    parameter int INTER_SECS = 3,
    parameter int NUM_ROUNDS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
`ifdef ROUND_PAUSE_EN
    input  logic       pause,
`endif
    output logic [1:0] round,
    output logic [5:0] time_left,
    output logic [7:0] score,
    output logic       playing,
    output logic       round_done,
    output logic       game_over
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(CLK_HZ - 1);
    localparam logic [5:0]    RSECS = 6'(ROUND_SECS);
    localparam logic [5:0]    ISECS = 6'(INTER_SECS);
    localparam logic [1:0]    NR    = 2'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        INTER = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] presc, presc_d;
    logic [1:0]    round_d;
    logic [5:0]    tl_d;
    logic [7:0]    score_d;
    logic          done_d;
    logic          frozen;
    logic          tick;

`ifdef ROUND_PAUSE_EN
    assign frozen = pause;
`else
    assign frozen = 1'b0;
`endif

    assign tick = (presc == PMAX) && !frozen;

    always_comb begin
        state_d = state;
        presc_d = presc;
        round_d = round;
        tl_d    = time_left;
        score_d = score;
        done_d  = 1'b0;
        unique case (state)
            IDLE, OVER: begin
                presc_d = '0;
                if (start) begin
                    state_d = PLAY;
                    round_d = 2'd1;
                    tl_d    = RSECS;
                    score_d = '0;
                end
            end
            PLAY: begin
                if (!frozen) begin
                    presc_d = tick ? '0 : presc + 1'b1;
                    if (hit && score != 8'hff)
                        score_d = score + 8'd1;
                    if (tick) begin
                        if (time_left > 6'd1) begin
                            tl_d = time_left - 6'd1;
                        end else begin
                            done_d  = 1'b1;
                            presc_d = '0;
                            if (round >= NR) begin
                                state_d = OVER;
                                tl_d    = '0;
                            end else begin
                                state_d = INTER;
                                tl_d    = ISECS;
                            end
                        end
                    end
                end
            end
            INTER: begin
                if (!frozen) begin
                    presc_d = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (time_left > 6'd1) begin
                            tl_d = time_left - 6'd1;
                        end else begin
                            state_d = PLAY;
                            presc_d = '0;
                            round_d = round + 2'd1;
                            tl_d    = RSECS;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            round      <= '0;
            time_left  <= '0;
            score      <= '0;
            playing    <= 1'b0;
            round_done <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            round      <= round_d;
            time_left  <= tl_d;
            score      <= score_d;
            playing    <= (state_d == PLAY) && !frozen;
            round_done <= done_d;
            game_over  <= (state_d == OVER);
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: vector table for a full game plus
// sequences for saturation, async reset, single-round game and pause.
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] round;
    logic [5:0] time_left;
    logic [7:0] score;
    logic       playing, round_done, game_over;

    logic       start2 = 1'b0;
    logic       hit2 = 1'b0;
    logic [1:0] round2;
    logic [5:0] time_left2;
    logic [7:0] score2;
    logic       playing2, round_done2, game_over2;

`ifdef ROUND_PAUSE_EN
    logic       pause = 1'b0;
    logic       pause2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    round_ctrl #(
        .CLK_HZ(4), .ROUND_SECS(3), .INTER_SECS(2), .NUM_ROUNDS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit),
`ifdef ROUND_PAUSE_EN
        .pause(pause),
`endif
        .round(round), .time_left(time_left), .score(score),
        .playing(playing), .round_done(round_done), .game_over(game_over)
    );

    round_ctrl #(
        .CLK_HZ(1000), .ROUND_SECS(1), .INTER_SECS(1), .NUM_ROUNDS(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .hit(hit2),
`ifdef ROUND_PAUSE_EN
        .pause(pause2),
`endif
        .round(round2), .time_left(time_left2), .score(score2),
        .playing(playing2), .round_done(round_done2), .game_over(game_over2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic ht;
        int   n;
        int   er;
        int   et;
        int   es;
        logic ep;
        logic eo;
        logic ed;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int er, input int et,
                           input int es, input logic ep, input logic eo,
                           input logic ed);
        chk({tag, " round"}, 32'(round), 32'(er));
        chk({tag, " time_left"}, 32'(time_left), 32'(et));
        chk({tag, " score"}, 32'(score), 32'(es));
        chk({tag, " playing"}, 32'(playing), 32'(ep));
        chk({tag, " game_over"}, 32'(game_over), 32'(eo));
        chk({tag, " round_done"}, 32'(round_done), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // st ht n  round tl score play over done
        vq.push_back('{1'b1, 1'b0, 1, 1, 3, 0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 1, 3, 1, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 1, 3, 2, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 1, 3, 3, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1, 1, 2, 3, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4, 1, 1, 4, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 3, 1, 1, 4, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 1, 2, 5, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1, 1, 2, 5, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 1, 2, 5, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 2, 1, 1, 5, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 3, 1, 1, 5, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 2, 3, 5, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 2, 3, 6, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1, 2, 3, 6, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 2, 3, 7, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 1, 2, 2, 8, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b1, 4, 2, 1, 9, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 3, 2, 1, 9, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1, 2, 0, 9, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1, 2, 0, 9, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 5, 2, 0, 9, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1, 1, 3, 0, 1'b1, 1'b0, 1'b0});

        #23;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk_all($sformatf("idle%0d", i), 0, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        foreach (vq[i]) begin
            start = vq[i].st;
            hit   = vq[i].ht;
            step();
            start = 1'b0;
            hit   = 1'b0;
            repeat (vq[i].n - 1) step();
            chk_all($sformatf("vec%0d", i), vq[i].er, vq[i].et, vq[i].es,
                    vq[i].ep, vq[i].eo, vq[i].ed);
        end

        // second game: round 2 starts 20 cycles in, reset 5 cycles later
        repeat (25) step();
        chk("mid r2 round", 32'(round), 32'd2);
        chk("mid r2 playing", 32'(playing), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst hold%0d round_done", i), 32'(round_done), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk_all("post rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // saturation and single-round game on the slow instance
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sat start round", 32'(round2), 32'd1);
        chk("sat start score", 32'(score2), 32'd0);
        hit2 = 1'b1;
        repeat (254) step();
        chk("sat 254", 32'(score2), 32'd254);
        step();
        chk("sat 255", 32'(score2), 32'd255);
        repeat (45) step();
        hit2 = 1'b0;
        chk("sat 300", 32'(score2), 32'd255);
        chk("sat playing", 32'(playing2), 32'd1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 1200 && !seen; i++) begin
                step();
                if (round_done2) seen = 1'b1;
            end
            chk("r1 game done seen", 32'(seen), 32'd1);
            chk("r1 game over", 32'(game_over2), 32'd1);
            chk("r1 game round", 32'(round2), 32'd1);
            chk("r1 game score", 32'(score2), 32'd255);
        end

`ifdef ROUND_PAUSE_EN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        hit   = 1'b1;
        repeat (10) step();
        chk("pause playing", 32'(playing), 32'd0);
        pause = 1'b0;
        hit   = 1'b0;
        chk("pause tl", 32'(time_left), 32'd3);
        chk("pause score", 32'(score), 32'd0);
        repeat (10) step();
        chk("pause pre-expiry done", 32'(round_done), 32'd0);
        chk("pause pre-expiry tl", 32'(time_left), 32'd1);
        step();
        chk("pause expiry done", 32'(round_done), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
